// File: rtl/and_nand_xnor_gates.sv
// and_nand_xnor_gates
//   Registered two-operand bitwise logic unit. AND, NAND and XNOR of two
//   WIDTH-bit operands are computed per bit and loaded into output registers
//   on a rising clk edge with in_valid=1. Results hold when in_valid=0.
//
// Parameters
//   WIDTH      operand/result width, 1..64 (default 1)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset; clears every output
//   in_valid   A/B valid this cycle; loads the result registers
//   A, B       operands
//   Y_and      registered A & B
//   Y_nand     registered ~(A & B)
//   Y_xnor     registered ~(A ^ B)
//   out_valid  result registers were loaded on the previous edge
//   and_any    registered |(A & B)   (status)
//   eq         registered &~(A ^ B)  (status, i.e. A == B)
//
// Configuration
//   GATES_STATUS_EN  when defined, and_any/eq are registered reductions;
//                    when undefined, they are tied to 0 and no reduction
//                    logic is built.

// Single bit position: the three gates, purely combinational.
module and_nand_xnor_lane (
  input  logic a,
  input  logic b,
  output logic y_and,
  output logic y_nand,
  output logic y_xnor
);
  assign y_and  = a & b;
  assign y_nand = ~(a & b);
  assign y_xnor = ~(a ^ b);
endmodule

module and_nand_xnor_gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y_and,
  output logic [WIDTH-1:0] Y_nand,
  output logic [WIDTH-1:0] Y_xnor,
  output logic             out_valid,
  output logic             and_any,
  output logic             eq
);

  logic [WIDTH-1:0] lane_and, lane_nand, lane_xnor;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    and_nand_xnor_lane u_lane (
      .a      (A[g]),
      .b      (B[g]),
      .y_and  (lane_and[g]),
      .y_nand (lane_nand[g]),
      .y_xnor (lane_xnor[g])
    );
  end

  logic [WIDTH-1:0] y_and_d,  y_and_q;
  logic [WIDTH-1:0] y_nand_d, y_nand_q;
  logic [WIDTH-1:0] y_xnor_d, y_xnor_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    y_and_d     = y_and_q;
    y_nand_d    = y_nand_q;
    y_xnor_d    = y_xnor_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      y_and_d  = lane_and;
      y_nand_d = lane_nand;
      y_xnor_d = lane_xnor;
    end
  end

  // Y_nand resets to 0 too, so it is not ~Y_and while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_and_q     <= '0;
      y_nand_q    <= '0;
      y_xnor_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_and_q     <= y_and_d;
      y_nand_q    <= y_nand_d;
      y_xnor_q    <= y_xnor_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Y_and     = y_and_q;
  assign Y_nand    = y_nand_q;
  assign Y_xnor    = y_xnor_q;
  assign out_valid = out_valid_q;

`ifdef GATES_STATUS_EN
  logic and_any_d, and_any_q;
  logic eq_d, eq_q;

  // Reductions taken from the lane outputs so they match the loaded vectors.
  always_comb begin
    and_any_d = and_any_q;
    eq_d      = eq_q;
    if (in_valid) begin
      and_any_d = |lane_and;
      eq_d      = &lane_xnor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      and_any_q <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      and_any_q <= and_any_d;
      eq_q      <= eq_d;
    end
  end

  assign and_any = and_any_q;
  assign eq      = eq_q;
`else
  assign and_any = 1'b0;
  assign eq      = 1'b0;
`endif

endmodule

// File: tb/tb_and_nand_xnor_gates.sv
// Bench for and_nand_xnor_gates: a WIDTH=8 and a WIDTH=1 instance share
// in_valid; the 1-bit instance sees bit 0 of the 8-bit operands. Expected
// results are pushed to a queue at drive time and popped when out_valid rises.
module tb_and_nand_xnor_gates;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a8, b8;

  logic [7:0] y_and8, y_nand8, y_xnor8;
  logic       ov8, any8, eq8;
  logic [0:0] y_and1, y_nand1, y_xnor1;
  logic       ov1, any1, eq1;

  always #5 clk = ~clk;

  and_nand_xnor_gates #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a8), .B(b8),
    .Y_and(y_and8), .Y_nand(y_nand8), .Y_xnor(y_xnor8),
    .out_valid(ov8), .and_any(any8), .eq(eq8)
  );

  and_nand_xnor_gates #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a8[0:0]), .B(b8[0:0]),
    .Y_and(y_and1), .Y_nand(y_nand1), .Y_xnor(y_xnor1),
    .out_valid(ov1), .and_any(any1), .eq(eq1)
  );

  typedef struct {
    logic [7:0] y_and;
    logic [7:0] y_nand;
    logic [7:0] y_xnor;
    logic       any8;
    logic       eq8;
    logic       any1;
    logic       eq1;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.y_and  = a & b;
    e.y_nand = ~(a & b);
    e.y_xnor = ~(a ^ b);
`ifdef GATES_STATUS_EN
    e.any8 = |(a & b);
    e.eq8  = (a == b);
    e.any1 = a[0] & b[0];
    e.eq1  = (a[0] == b[0]);
`else
    e.any8 = 1'b0;
    e.eq8  = 1'b0;
    e.any1 = 1'b0;
    e.eq1  = 1'b0;
`endif
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.y_and = '0; e.y_nand = '0; e.y_xnor = '0;
    e.any8 = 1'b0; e.eq8 = 1'b0; e.any1 = 1'b0; e.eq1 = 1'b0;
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e, input logic v);
    check({tag, ".ov8"},    64'(ov8), 64'(v));
    check({tag, ".ov1"},    64'(ov1), 64'(v));
    check({tag, ".and8"},   64'(y_and8), 64'(e.y_and));
    check({tag, ".nand8"},  64'(y_nand8), 64'(e.y_nand));
    check({tag, ".xnor8"},  64'(y_xnor8), 64'(e.y_xnor));
    check({tag, ".any8"},   64'(any8), 64'(e.any8));
    check({tag, ".eq8"},    64'(eq8), 64'(e.eq8));
    check({tag, ".and1"},   64'(y_and1), 64'(e.y_and[0]));
    check({tag, ".nand1"},  64'(y_nand1), 64'(e.y_nand[0]));
    check({tag, ".xnor1"},  64'(y_xnor1), 64'(e.y_xnor[0]));
    check({tag, ".any1"},   64'(any1), 64'(e.any1));
    check({tag, ".eq1"},    64'(eq1), 64'(e.eq1));
  endtask

  // Drive one cycle, then compare 1 ns after the edge.
  task automatic step(input string tag, input logic v, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    a8 = a;
    b8 = b;
    if (v) exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      held = exp_q.pop_front();
      check_all(tag, held, 1'b1);
    end else begin
      check_all(tag, held, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a8 = '0;
    b8 = '0;
    held = zero_exp();
    #3;
    check_all("reset", zero_exp(), 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1-bit truth table on bit 0 (00, 01, 10, 11), back to back.
    step("tt00", 1'b1, 8'h00, 8'h00);
    step("tt01", 1'b1, 8'h00, 8'h01);
    step("tt10", 1'b1, 8'h01, 8'h00);
    step("tt11", 1'b1, 8'h01, 8'h01);

    // Mixed pattern: and 0x30, nand 0xCF, xnor 0x33.
    step("f0_3c", 1'b1, 8'hF0, 8'h3C);

    // Equal operands, then drop in_valid with different operands: held.
    step("a5_eq", 1'b1, 8'hA5, 8'hA5);
    step("hold1", 1'b0, 8'h12, 8'h34);
    step("hold2", 1'b0, 8'hFF, 8'h00);

    // A few random back-to-back operands.
    for (int i = 0; i < 6; i++) begin
      step("rand", 1'b1, 8'($urandom), 8'($urandom));
    end

    // Load all-ones, then reset mid-cycle: outputs clear without an edge.
    step("ff_ff", 1'b1, 8'hFF, 8'hFF);
    in_valid = 1'b1;
    a8 = 8'h0F;
    b8 = 8'hF0;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    held = zero_exp();
    check_all("midrst", held, 1'b0);
    @(posedge clk);
    #1;
    check_all("inrst", held, 1'b0);
    rst = 1'b0;

    step("post_rst", 1'b1, 8'h5A, 8'h0F);
    step("post_ff", 1'b1, 8'hFF, 8'hFF);
    step("post_idle", 1'b0, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound: the directed sequence is far shorter than this.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
